cpu_sequencer: RTL and testbench

Multi-cycle sequencer for the single-cycle-decode CPU core.
- Orders FETCH → EXEC → (MEM) for each instruction.
- Shares one single-port memory between instruction fetch (address from PC) and store data (address from ALU).
- Gates the decoder's rf_we/mem_we so architectural state changes exactly once per instruction.
- Supports run and single-step modes, a retired-instruction counter and a memory-timeout bus error.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/cpu_sequencer_wait_timer.sv | 28 ++
 rtl/cpu_sequencer.sv | 139 +++++++++++++
 tb/tb_cpu_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: state encoding and memory address select values.
package cpu_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam logic MEM_SEL_PC  = 1'b0;
  localparam logic MEM_SEL_ALU = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_EXEC  = ST_EXEC,
    S_MEM   = ST_MEM,
    S_HALT  = ST_HALT
  } state_t;

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Wait-cycle counter for memory requests; flags when the count reaches the terminal value.
module wait_timer #(
  parameter int           W    = 8,
  parameter logic [W-1:0] TERM = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] count;

  // Clear has priority so every state entry starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == TERM);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM sequencer sharing one memory port, with step mode,
// retirement statistics and a memory-timeout bus error.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int TMR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             mem_ack,
  input  logic             ctl_rf_we,
  input  logic             ctl_mem_we,
  input  logic             ctl_jmp,
  output logic             mem_req,
  output logic             mem_addr_sel,
  output logic             mem_wr,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             busy,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] jmp_cnt
);

  localparam logic [TMR_W-1:0] TERM = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  state_t state, state_nxt;
  logic   step_mode;
  logic   retire;
  logic   in_wait;
  logic   expired;
  logic   timeout_hit;
  logic   go_idle;

  assign in_wait     = (state == S_FETCH) || (state == S_MEM);
  assign timeout_hit = (TIMEOUT != 0) && in_wait && !mem_ack && expired;
  assign go_idle     = step_mode || !run;

  wait_timer #(
    .W   (TMR_W),
    .TERM(TERM)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_nxt != state),
    .enable (in_wait && !mem_ack),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      step_mode   <= 1'b0;
      bus_err     <= 1'b0;
      retired_cnt <= '0;
      jmp_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && state_nxt == S_FETCH) begin
        step_mode <= !run;
      end
      if (timeout_hit) begin
        bus_err <= 1'b1;
      end
      if (retire) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
      if (retire && state == S_EXEC && ctl_jmp) begin
        jmp_cnt <= jmp_cnt + CNT_W'(1);
      end
    end
  end

  // The commit after EXEC or MEM decides IDLE vs FETCH directly, so there is no NEXT cycle.
  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    mem_addr_sel = MEM_SEL_PC;
    mem_wr       = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    rf_we        = 1'b0;
    retire       = 1'b0;
    case (state)
      S_IDLE: begin
        if (run || step) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we     = 1'b1;
          state_nxt = S_EXEC;
        end else if (timeout_hit) begin
          state_nxt = S_HALT;
        end
      end
      S_EXEC: begin
        if (ctl_mem_we) begin
          state_nxt = S_MEM;
        end else begin
          rf_we     = ctl_rf_we;
          pc_we     = 1'b1;
          retire    = 1'b1;
          state_nxt = go_idle ? S_IDLE : S_FETCH;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = MEM_SEL_ALU;
        mem_wr       = 1'b1;
        if (mem_ack) begin
          pc_we     = 1'b1;
          retire    = 1'b1;
          state_nxt = go_idle ? S_IDLE : S_FETCH;
        end else if (timeout_hit) begin
          state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with hand-computed expectations, TIMEOUT fixed at 4.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        mem_ack;
  logic        ctl_rf_we;
  logic        ctl_mem_we;
  logic        ctl_jmp;
  logic        mem_req;
  logic        mem_addr_sel;
  logic        mem_wr;
  logic        ir_we;
  logic        pc_we;
  logic        rf_we;
  logic        busy;
  logic        halted;
  logic        bus_err;
  logic [31:0] retired_cnt;
  logic [31:0] jmp_cnt;

  int checks = 0;
  int errors = 0;

  cpu_sequencer #(
    .CNT_W  (32),
    .TIMEOUT(4),
    .TMR_W  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .step        (step),
    .mem_ack     (mem_ack),
    .ctl_rf_we   (ctl_rf_we),
    .ctl_mem_we  (ctl_mem_we),
    .ctl_jmp     (ctl_jmp),
    .mem_req     (mem_req),
    .mem_addr_sel(mem_addr_sel),
    .mem_wr      (mem_wr),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .rf_we       (rf_we),
    .busy        (busy),
    .halted      (halted),
    .bus_err     (bus_err),
    .retired_cnt (retired_cnt),
    .jmp_cnt     (jmp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, then let combinational strobes settle after new inputs are applied.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic a,
                               input logic rfw, input logic mw, input logic j);
    run        = r;
    step       = s;
    mem_ack    = a;
    ctl_rf_we  = rfw;
    ctl_mem_we = mw;
    ctl_jmp    = j;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_halted", 32'(halted), 32'd0);
    checkOutput("reset_bus_err", 32'(bus_err), 32'd0);
    checkOutput("reset_retired", retired_cnt, 32'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    // Single step, zero-wait memory, register-writing instruction.
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("step_idle_busy", 32'(busy), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("step_fetch_req", 32'(mem_req), 32'd1);
    checkOutput("step_fetch_sel", 32'(mem_addr_sel), 32'd0);
    checkOutput("step_fetch_ir_we", 32'(ir_we), 32'd1);
    checkOutput("step_fetch_pc_we", 32'(pc_we), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("step_exec_rf_we", 32'(rf_we), 32'd1);
    checkOutput("step_exec_pc_we", 32'(pc_we), 32'd1);
    checkOutput("step_exec_req", 32'(mem_req), 32'd0);
    nextCycle();
    checkOutput("step_back_idle", 32'(busy), 32'd0);
    checkOutput("step_retired", retired_cnt, 32'd1);
    checkOutput("step_jmp", jmp_cnt, 32'd0);

    // Run mode, ack on the 4th fetch cycle (same cycle the timer would expire).
    applyStimulus(1, 0, 0, 1, 0, 0);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(1, 0, (k == 3), 1, 0, 0);
        checkOutput($sformatf("run_fetch_req_%0d_%0d", i, k), 32'(mem_req), 32'd1);
        checkOutput($sformatf("run_fetch_ir_%0d_%0d", i, k), 32'(ir_we), 32'(k == 3));
        checkOutput($sformatf("run_fetch_pc_%0d_%0d", i, k), 32'(pc_we), 32'd0);
        nextCycle();
      end
      applyStimulus((i != 2), 0, 0, 1, 0, (i == 1));
      checkOutput($sformatf("run_exec_pc_%0d", i), 32'(pc_we), 32'd1);
      checkOutput($sformatf("run_exec_rf_%0d", i), 32'(rf_we), 32'd1);
      checkOutput($sformatf("run_exec_ir_%0d", i), 32'(ir_we), 32'd0);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("run_idle_busy", 32'(busy), 32'd0);
    checkOutput("run_retired", retired_cnt, 32'd4);
    checkOutput("run_jmp", jmp_cnt, 32'd1);
    checkOutput("run_bus_err", 32'(bus_err), 32'd0);

    // Store instruction through MEM with one wait cycle.
    applyStimulus(0, 1, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 1, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("store_exec_pc_we", 32'(pc_we), 32'd0);
    checkOutput("store_exec_rf_we", 32'(rf_we), 32'd0);
    checkOutput("store_exec_req", 32'(mem_req), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("store_mem_req", 32'(mem_req), 32'd1);
    checkOutput("store_mem_sel", 32'(mem_addr_sel), 32'd1);
    checkOutput("store_mem_wr", 32'(mem_wr), 32'd1);
    checkOutput("store_mem_pc_wait", 32'(pc_we), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 1, 1, 1, 0);
    checkOutput("store_ack_pc_we", 32'(pc_we), 32'd1);
    checkOutput("store_ack_rf_we", 32'(rf_we), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("store_idle", 32'(busy), 32'd0);
    checkOutput("store_retired", retired_cnt, 32'd5);

    // Reset asserted while a store request is outstanding.
    applyStimulus(0, 1, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 1, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0);
    nextCycle();
    checkOutput("rst_mid_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_req_after", 32'(mem_req), 32'd0);
    checkOutput("rst_mid_retired", retired_cnt, 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("rst_release_idle", 32'(busy), 32'd0);

    // Fetch timeout: no ack for 4 cycles, run dropped mid-fetch.
    applyStimulus(1, 0, 0, 0, 0, 0);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("to_fetch_req_%0d", k), 32'(mem_req), 32'd1);
      checkOutput($sformatf("to_fetch_err_%0d", k), 32'(bus_err), 32'd0);
      nextCycle();
    end
    checkOutput("to_halted", 32'(halted), 32'd1);
    checkOutput("to_bus_err", 32'(bus_err), 32'd1);
    checkOutput("to_req_off", 32'(mem_req), 32'd0);
    checkOutput("to_busy", 32'(busy), 32'd0);
    applyStimulus(1, 1, 1, 1, 0, 0);
    nextCycle();
    nextCycle();
    checkOutput("to_halt_sticky", 32'(halted), 32'd1);
    checkOutput("to_halt_no_req", 32'(mem_req), 32'd0);
    checkOutput("to_halt_retired", retired_cnt, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("to_rst_halted", 32'(halted), 32'd0);
    checkOutput("to_rst_bus_err", 32'(bus_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
